// File: rtl/pipe_slice_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipe_slice_cfg
// Brief    : Cascaded valid/ready register slice with forward, skid and full
//            modes; PIPE_SLICE_CFG_STALL_CNT_EN adds stall_cnt and occupancy.
// Revision : 1.0
// ============================================================================
module pipe_slice_cfg #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1,
  parameter int MODE   = 0
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           valid_up,
  input  logic [DATA_W-1:0]              data_up,
  output logic                           ready_up,
  output logic                           valid_down,
  output logic [DATA_W-1:0]              data_down,
  input  logic                           ready_down
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt,
  output logic [$clog2(2*STAGES+1)-1:0]  occupancy
`endif
);

  localparam int c_ENTRIES = (MODE == 2) ? 2 * STAGES : STAGES;

  if (MODE < 0 || MODE > 2 || STAGES < 1 || STAGES > 8 || DATA_W < 1 || DATA_W > 64)
  begin : g_bad_params
    $error("pipe_slice_cfg: illegal parameter set");
  end

`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
  localparam int c_OCC_W = $clog2(2*STAGES+1);
  logic [c_ENTRIES-1:0] w_full_vec;
`endif

  // Each entry is either a forward register or a skid buffer; full mode
  // alternates them so even entries are forward and odd entries are skid.
  for (genvar i = 0; i < c_ENTRIES; i++) begin : g_ent
    logic              w_valid_in;
    logic [DATA_W-1:0] w_data_in;
    logic              w_ready_out;
    logic              w_ready_in;
    logic              w_valid_out;
    logic [DATA_W-1:0] w_data_out;

    if (i == 0) begin : g_head
      assign w_valid_in = valid_up;
      assign w_data_in  = data_up;
    end else begin : g_link
      assign w_valid_in = g_ent[i-1].w_valid_out;
      assign w_data_in  = g_ent[i-1].w_data_out;
    end

    if (i == c_ENTRIES - 1) begin : g_tail
      assign w_ready_out = ready_down;
    end else begin : g_next
      assign w_ready_out = g_ent[i+1].w_ready_in;
    end

    if (MODE == 0 || (MODE == 2 && (i % 2) == 0)) begin : g_fwd
      logic              r_v;
      logic [DATA_W-1:0] r_d;

      assign w_ready_in  = w_ready_out | ~r_v;
      assign w_valid_out = r_v;
      assign w_data_out  = r_d;

      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_d <= '0;
        end else if (flush) begin
          r_v <= 1'b0;
        end else if (w_ready_in) begin
          r_v <= w_valid_in;
          if (w_valid_in) begin
            r_d <= w_data_in;
          end
        end
      end

`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
      assign w_full_vec[i] = r_v;
`endif
    end else begin : g_skid
      logic              r_sv;
      logic [DATA_W-1:0] r_sd;

      // ready_in comes straight from a flop, breaking the ready path.
      assign w_ready_in  = ~r_sv;
      assign w_valid_out = w_valid_in | r_sv;
      assign w_data_out  = r_sv ? r_sd : w_data_in;

      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sv <= 1'b0;
          r_sd <= '0;
        end else if (flush) begin
          r_sv <= 1'b0;
        end else if (r_sv) begin
          if (w_ready_out) begin
            r_sv <= 1'b0;
          end
        end else if (w_valid_in && !w_ready_out) begin
          r_sv <= 1'b1;
          r_sd <= w_data_in;
        end
      end

`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
      assign w_full_vec[i] = r_sv;
`endif
    end
  end

  assign ready_up   = g_ent[0].w_ready_in;
  assign valid_down = g_ent[c_ENTRIES-1].w_valid_out;
  assign data_down  = g_ent[c_ENTRIES-1].w_data_out;

`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
  logic [15:0]        r_stall_cnt;
  logic [c_OCC_W-1:0] w_occ;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (valid_down && !ready_down && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int j = 0; j < c_ENTRIES; j++) begin
      w_occ = w_occ + c_OCC_W'(w_full_vec[j]);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign occupancy = w_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_slice_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_slice_cfg
// Brief    : Directed and random checks of pipe_slice_cfg in all three modes;
//            stall counter checks when PIPE_SLICE_CFG_STALL_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_pipe_slice_cfg;

  logic        sys_clk;
  logic        rst_n;
  logic        flush;
  logic        vu [3];
  logic [15:0] du [3];
  logic        ru [3];
  logic        vd [3];
  logic [15:0] dd [3];
  logic        rd [3];
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
  logic [15:0] sc [3];
  logic [1:0]  occ0;
  logic [1:0]  occ1;
  logic [2:0]  occ2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  pipe_slice_cfg #(.DATA_W(16), .STAGES(1), .MODE(0)) u_dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .flush(flush),
    .valid_up(vu[0]), .data_up(du[0]), .ready_up(ru[0]),
    .valid_down(vd[0]), .data_down(dd[0]), .ready_down(rd[0])
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
    , .stall_cnt(sc[0]), .occupancy(occ0)
`endif
  );

  pipe_slice_cfg #(.DATA_W(16), .STAGES(1), .MODE(1)) u_dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .flush(flush),
    .valid_up(vu[1]), .data_up(du[1]), .ready_up(ru[1]),
    .valid_down(vd[1]), .data_down(dd[1]), .ready_down(rd[1])
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
    , .stall_cnt(sc[1]), .occupancy(occ1)
`endif
  );

  pipe_slice_cfg #(.DATA_W(16), .STAGES(3), .MODE(2)) u_dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .flush(flush),
    .valid_up(vu[2]), .data_up(du[2]), .ready_up(ru[2]),
    .valid_down(vd[2]), .data_down(dd[2]), .ready_down(rd[2])
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
    , .stall_cnt(sc[2]), .occupancy(occ2)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vu[k] = 1'b0; du[k] = 16'h0; rd[k] = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (vd[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid_down[%0d] got=%b exp=0", k, vd[k]); end
      n_checks++;
      if (dd[k] !== 16'h0) begin n_fail++; $display("FAIL reset_data_down[%0d] got=%h exp=0000", k, dd[k]); end
      n_checks++;
      if (ru[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_up[%0d] got=%b exp=1", k, ru[k]); end
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
      n_checks++;
      if (sc[k] !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt[%0d] got=%h exp=0000", k, sc[k]); end
`endif
    end
    rst_n = 1'b1;
  endtask

  // MODE 0: beats 1..8 back-to-back, each appears exactly one cycle later.
  task automatic test_fwd_stream();
    rd[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      vu[0] = (c < 8);
      du[0] = (c < 8) ? 16'(c + 1) : 16'h0;
      #1;
      if (c < 8) begin
        n_checks++;
        if (ru[0] !== 1'b1) begin n_fail++; $display("FAIL fwd_ready_up c=%0d got=%b exp=1", c, ru[0]); end
      end
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (vd[0] !== 1'b1 || dd[0] !== 16'(c)) begin
          n_fail++; $display("FAIL fwd_stream c=%0d got v=%b d=%h exp v=1 d=%h", c, vd[0], dd[0], 16'(c));
        end
      end else begin
        n_checks++;
        if (vd[0] !== 1'b0) begin n_fail++; $display("FAIL fwd_bubble c=%0d got v=%b exp v=0", c, vd[0]); end
      end
    end
    vu[0] = 1'b0;
  endtask

  // MODE 1: downstream stalls for one cycle as beat 3 passes through.
  task automatic test_skid();
    int nxt;
    int exp_b;
    nxt = 1; exp_b = 1;
    for (int c = 0; c < 30 && exp_b <= 8; c++) begin
      @(negedge sys_clk);
      vu[1] = (nxt <= 8);
      du[1] = 16'(nxt);
      rd[1] = (c != 2);
      #1;
      if (c == 2) begin
        n_checks++;
        if (ru[1] !== 1'b1 || vd[1] !== 1'b1 || dd[1] !== 16'h3) begin
          n_fail++; $display("FAIL skid_stall_cycle got ru=%b v=%b d=%h exp ru=1 v=1 d=0003", ru[1], vd[1], dd[1]);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (ru[1] !== 1'b0 || dd[1] !== 16'h3) begin
          n_fail++; $display("FAIL skid_held got ru=%b d=%h exp ru=0 d=0003", ru[1], dd[1]);
        end
      end
      if (vd[1] && rd[1]) begin
        n_checks++;
        if (dd[1] !== 16'(exp_b)) begin n_fail++; $display("FAIL skid_order got=%h exp=%h", dd[1], 16'(exp_b)); end
        exp_b++;
      end
      if (vu[1] && ru[1]) nxt++;
    end
    vu[1] = 1'b0;
    n_checks++;
    if (exp_b != 9) begin n_fail++; $display("FAIL skid_count got=%0d exp=8", exp_b - 1); end
  endtask

  // MODE 2, 3 stages: 6 entries fill, drain in order, then 3-cycle latency.
  task automatic test_capacity();
    int acc;
    int exp_b;
    int lat;
    acc = 0; exp_b = 0; lat = -1;
    rd[2] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      vu[2] = 1'b1;
      du[2] = 16'h0100 + 16'(acc);
      #1;
      if (ru[2]) acc++;
    end
    n_checks++;
    if (acc != 6 || ru[2] !== 1'b0) begin
      n_fail++; $display("FAIL capacity got accepted=%0d ru=%b exp accepted=6 ru=0", acc, ru[2]);
    end
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
    n_checks++;
    if (occ2 !== 3'd6) begin n_fail++; $display("FAIL occupancy_full got=%0d exp=6", occ2); end
`endif
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      vu[2] = 1'b0;
      rd[2] = 1'b1;
      #1;
      if (vd[2]) begin
        n_checks++;
        if (dd[2] !== 16'h0100 + 16'(exp_b)) begin
          n_fail++; $display("FAIL capacity_drain got=%h exp=%h", dd[2], 16'h0100 + 16'(exp_b));
        end
        exp_b++;
      end
    end
    n_checks++;
    if (exp_b != 6) begin n_fail++; $display("FAIL capacity_drain_count got=%0d exp=6", exp_b); end

    @(negedge sys_clk);
    vu[2] = 1'b1; du[2] = 16'h0ABC;
    #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge sys_clk);
      vu[2] = 1'b0;
      #1;
      if (vd[2] && lat < 0) begin
        lat = c;
        n_checks++;
        if (dd[2] !== 16'h0ABC) begin n_fail++; $display("FAIL latency_data got=%h exp=0abc", dd[2]); end
      end
    end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL latency got=%0d exp=3", lat); end
  endtask

  task automatic test_flush();
    int leaked;
    leaked = 0;
    // MODE 0: flush wins over a simultaneous load and unload.
    @(negedge sys_clk);
    rd[0] = 1'b0; vu[0] = 1'b1; du[0] = 16'h0055;
    @(negedge sys_clk);
    vu[0] = 1'b1; du[0] = 16'h0066; rd[0] = 1'b1; flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0; vu[0] = 1'b0;
    #1;
    n_checks++;
    if (vd[0] !== 1'b0 || ru[0] !== 1'b1 || dd[0] !== 16'h0055) begin
      n_fail++; $display("FAIL flush_m0 got v=%b ru=%b d=%h exp v=0 ru=1 d=0055", vd[0], ru[0], dd[0]);
    end
    // MODE 1 and MODE 2: fill, flush, nothing emerges.
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      for (int k = 1; k < 3; k++) begin
        rd[k] = 1'b0; vu[k] = 1'b1; du[k] = 16'h0200 + 16'(c);
      end
    end
    @(negedge sys_clk);
    flush = 1'b1; vu[1] = 1'b0; vu[2] = 1'b0;
    @(negedge sys_clk);
    flush = 1'b0;
    #1;
    for (int k = 1; k < 3; k++) begin
      n_checks++;
      if (vd[k] !== 1'b0 || ru[k] !== 1'b1) begin
        n_fail++; $display("FAIL flush_m%0d got v=%b ru=%b exp v=0 ru=1", k, vd[k], ru[k]);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      rd[0] = 1'b1; rd[1] = 1'b1; rd[2] = 1'b1;
      #1;
      if (vd[0] || vd[1] || vd[2]) leaked++;
    end
    n_checks++;
    if (leaked != 0) begin n_fail++; $display("FAIL flush_leak got=%0d exp=0", leaked); end
  endtask

  task automatic test_reset_mid();
    @(negedge sys_clk);
    rd[0] = 1'b0; vu[0] = 1'b1; du[0] = 16'h005A;
    @(negedge sys_clk);
    vu[0] = 1'b0;
    #1;
    n_checks++;
    if (vd[0] !== 1'b1 || dd[0] !== 16'h005A) begin
      n_fail++; $display("FAIL reset_mid_pre got v=%b d=%h exp v=1 d=005a", vd[0], dd[0]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vd[0] !== 1'b0 || dd[0] !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid got v=%b d=%h exp v=0 d=0000", vd[0], dd[0]);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int k);
    logic [15:0] q[$];
    int          sent;
    int          got;
    int          cyc;
    logic        up_take;
    logic        hold_v;
    logic [15:0] hold_d;
    sent = 0; got = 0; cyc = 0; up_take = 1'b0; hold_v = 1'b0; hold_d = 16'h0;
    vu[k] = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge sys_clk);
      cyc++;
      if (!vu[k] || up_take) begin
        vu[k] = (sent < 1000) && ($urandom_range(0, 1) == 1);
        du[k] = 16'($urandom);
      end
      rd[k] = ($urandom_range(0, 1) == 1);
      #1;
      if (hold_v) begin
        n_checks++;
        if (vd[k] !== 1'b1 || dd[k] !== hold_d) begin
          n_fail++; $display("FAIL rnd_stable[%0d] got v=%b d=%h exp v=1 d=%h", k, vd[k], dd[k], hold_d);
        end
      end
      up_take = vu[k] && ru[k];
      if (up_take) begin
        q.push_back(du[k]);
        sent++;
      end
      if (vd[k] && rd[k]) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra[%0d] got=%h exp=none", k, dd[k]);
        end else begin
          if (dd[k] !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got=%h exp=%h", k, dd[k], q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      hold_v = vd[k] && !rd[k];
      hold_d = dd[k];
    end
    vu[k] = 1'b0;
    n_checks++;
    if (got != 1000 || q.size() != 0) begin
      n_fail++; $display("FAIL rnd_count[%0d] got=%0d left=%0d exp=1000 left=0", k, got, q.size());
    end
  endtask

`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
  task automatic test_stall_cnt();
    @(negedge sys_clk);
    rd[0] = 1'b0; vu[0] = 1'b1; du[0] = 16'h0077;
    @(negedge sys_clk);
    vu[0] = 1'b0;
    repeat (10) @(negedge sys_clk);
    #1;
    n_checks++;
    if (sc[0] !== 16'd10 || occ0 !== 2'd1) begin
      n_fail++; $display("FAIL stall_cnt_10 got cnt=%0d occ=%0d exp cnt=10 occ=1", sc[0], occ0);
    end
    repeat (66000) @(negedge sys_clk);
    #1;
    n_checks++;
    if (sc[0] !== 16'hFFFF) begin n_fail++; $display("FAIL stall_cnt_sat got=%h exp=ffff", sc[0]); end
    @(negedge sys_clk);
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (sc[0] !== 16'h0 || occ0 !== 2'd0) begin
      n_fail++; $display("FAIL stall_cnt_flush got cnt=%h occ=%0d exp cnt=0000 occ=0", sc[0], occ0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_stream();
    test_skid();
    test_capacity();
    test_flush();
    test_reset_mid();
    for (int k = 0; k < 3; k++) test_random(k);
`ifdef PIPE_SLICE_CFG_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
